// File: rtl/dmem_port_arb_pkg.sv
// Shared types for the data-memory port arbiter: word type, FSM states and
// grant identifiers.
package dmem_port_arb_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SLS  = 2'd1,
    ARB_MLS  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_SLS = 1'b0,
    GNT_MLS = 1'b1
  } gnt_t;

  // Map a picker decision onto the FSM state that serves it.
  function automatic arb_state_t gnt_to_state(gnt_t g);
    return (g == GNT_SLS) ? ARB_SLS : ARB_MLS;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module dmem_rr_pick
  import dmem_port_arb_pkg::*;
(
  input  logic req_s,
  input  logic req_m,
  input  gnt_t last_gnt,
  output logic grant_valid,
  output gnt_t grant
);

  // Pick the winner; tie broken against the previous grant.
  always_comb begin
    grant_valid = req_s | req_m;
    grant       = GNT_SLS;
    if (req_s && req_m) begin
      grant = (last_gnt == GNT_SLS) ? GNT_MLS : GNT_SLS;
    end else if (req_m) begin
      grant = GNT_MLS;
    end
  end

endmodule

// File: rtl/dmem_port_arb.sv
// Data-memory port arbiter between the scalar (sls) and matrix (mls)
// load/store units. One grant at a time, with a watchdog on stuck accesses.
//
// Handshake: a requester raises REN and/or WEN (WEN wins when both are high)
// with address/data stable and holds them until its hit pulse; hit is a
// single-cycle completion strobe with load data valid in that same cycle.
// Dropping the request while granted withdraws it with no hit. On the memory
// side mem_ren|mem_wen is the request and mem_wait==0 marks completion.
module dmem_port_arb
  import dmem_port_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              sls_dmemREN,
  input  logic              sls_dmemWEN,
  input  logic [ADDR_W-1:0] sls_dmemaddr,
  input  logic [DATA_W-1:0] sls_dmemstore,
  output logic              sls_dhit,
  output logic [DATA_W-1:0] sls_dmemload,
  input  logic              mls_ren,
  input  logic              mls_wen,
  input  logic [ADDR_W-1:0] mls_addr,
  input  logic [DATA_W-1:0] mls_store,
  output logic              mls_hit,
  output logic [DATA_W-1:0] mls_load,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_store,
  input  logic              mem_wait,
  input  logic [DATA_W-1:0] mem_load,
  output logic              busy,
  output logic              timeout_err,
  output arb_state_t        state_dbg
);

  // Counter is sized to hold TIMEOUT; a disabled watchdog keeps one idle bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t        state, state_nxt;
  gnt_t              last_gnt, last_gnt_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              err_nxt;

  logic              sls_act, mls_act;
  logic              pick_valid;
  gnt_t              pick;

  logic              g_ren, g_wen, g_act;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_store;
  logic              complete;
  logic [DATA_W-1:0] load_val;

  assign sls_act = sls_dmemREN | sls_dmemWEN;
  assign mls_act = mls_ren | mls_wen;

  dmem_rr_pick u_pick (
    .req_s       (sls_act),
    .req_m       (mls_act),
    .last_gnt    (last_gnt),
    .grant_valid (pick_valid),
    .grant       (pick)
  );

  // Select the live request of whichever FU currently owns the port.
  always_comb begin
    g_ren   = 1'b0;
    g_wen   = 1'b0;
    g_addr  = '0;
    g_store = '0;
    case (state)
      ARB_SLS: begin
        g_ren   = sls_dmemREN;
        g_wen   = sls_dmemWEN;
        g_addr  = sls_dmemaddr;
        g_store = sls_dmemstore;
      end
      ARB_MLS: begin
        g_ren   = mls_ren;
        g_wen   = mls_wen;
        g_addr  = mls_addr;
        g_store = mls_store;
      end
      default: ;
    endcase
  end

  assign g_act     = g_ren | g_wen;
  assign mem_wen   = g_wen;
  assign mem_ren   = g_ren & ~g_wen;
  assign mem_addr  = g_act ? g_addr : '0;
  assign mem_store = g_act ? g_store : '0;

  // Completion beats a same-cycle withdrawal; writes return zero load data.
  assign complete     = (state != ARB_IDLE) && !mem_wait;
  assign load_val     = g_wen ? '0 : mem_load;
  assign sls_dhit     = complete && (state == ARB_SLS);
  assign mls_hit      = complete && (state == ARB_MLS);
  assign sls_dmemload = sls_dhit ? load_val : '0;
  assign mls_load     = mls_hit ? load_val : '0;

  assign busy      = (state != ARB_IDLE);
  assign state_dbg = state;

  // Next-state, round-robin history and watchdog decisions.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = timeout_err;
    case (state)
      ARB_IDLE: begin
        wait_cnt_nxt = '0;
        if (pick_valid) begin
          state_nxt    = gnt_to_state(pick);
          last_gnt_nxt = pick;
        end
      end
      ARB_SLS, ARB_MLS: begin
        if (!mem_wait || !g_act) begin
          state_nxt    = ARB_IDLE;
          wait_cnt_nxt = '0;
        end else if ((TIMEOUT > 0) && (wait_cnt == CNT_LAST)) begin
          state_nxt    = ARB_IDLE;
          wait_cnt_nxt = '0;
          err_nxt      = 1'b1;
        end else if ((TIMEOUT > 0) && (wait_cnt != CNT_MAX)) begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = ARB_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // State, grant history, watchdog counter and sticky error registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= ARB_IDLE;
      last_gnt    <= GNT_MLS;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_gnt    <= last_gnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
      timeout_err <= err_nxt;
    end
  end

endmodule
